// File: rtl/regfile_2r1w.sv
// 32-entry, 2-read/1-write register file; entry 0 reads as zero.
// Latency: reads are combinational; writes commit on the rising clk. Optional same-cycle write bypass.
// Backpressure: none; a write is accepted on every cycle that we is high.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage; index 0 is decoded to zero on every read path.
    logic [DATA_W-1:0] mem_q [1:DEPTH-1];
    logic [DATA_W-1:0] mem_d [1:DEPTH-1];

    logic wr_en;
    logic hit_a;
    logic hit_b;

    assign wr_en = we && (waddr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] idx);
        if (idx == '0) begin
            return '0;
        end
        return mem_q[idx];
    endfunction

    // wdata goes straight into the output mux: it is the critical path.
    assign hit_a = (BYPASS != 0) && rst_n && wr_en && (waddr == raddr_a);
    assign hit_b = (BYPASS != 0) && rst_n && wr_en && (waddr == raddr_b);

    assign rdata_a  = hit_a ? wdata : stored(raddr_a);
    assign rdata_b  = hit_b ? wdata : stored(raddr_b);
    assign dbg_data = stored(dbg_addr);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one bypassing and one non-bypassing instance on shared stimulus.
module tb_regfile_2r1w;
    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  dbg_addr;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [31:0] dbg_data;
    logic [31:0] nb_rdata_a;
    logic [31:0] nb_rdata_b;
    logic [31:0] nb_dbg_data;

    int total = 0;
    int bad   = 0;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(raddr_a), .rdata_a(rdata_a),
        .raddr_b(raddr_b), .rdata_b(rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .raddr_a(raddr_a), .rdata_a(nb_rdata_a),
        .raddr_b(raddr_b), .rdata_b(nb_rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An unknown write index while writing is a protocol error.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            assert (!$isunknown(waddr)) else $error("X waddr with we=1");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Return 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = 5'd5; raddr_b = 5'd31; dbg_addr = 5'd1;
        #2;
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_dbg", dbg_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset clears a loaded register between edges.
        write_reg(5'd5, 32'hDEADBEEF);
        dbg_addr = 5'd5; raddr_a = 5'd5; raddr_b = 5'd5;
        #1;
        check("r5_loaded_dbg", dbg_data, 32'hDEADBEEF);
        check("r5_loaded_a", rdata_a, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dbg", dbg_data, 32'h0);
        check("async_rst_a", rdata_a, 32'h0);
        check("async_rst_b", rdata_b, 32'h0);

        // Write held across an edge while in reset is dropped, and bypass is suppressed.
        we = 1'b1; waddr = 5'd3; wdata = 32'h77; raddr_a = 5'd3; dbg_addr = 5'd3;
        #1;
        check("rst_no_bypass", rdata_a, 32'h0);
        tick();
        we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_drop_r3", dbg_data, 32'h0);
        write_reg(5'd3, 32'h88);
        check("post_rst_write_r3", dbg_data, 32'h88);

        // Basic writes and dual-port read.
        write_reg(5'd1, 32'h12345678);
        write_reg(5'd31, 32'hFFFFFFFF);
        raddr_a = 5'd1; raddr_b = 5'd31;
        #1;
        check("rd_a_r1", rdata_a, 32'h12345678);
        check("rd_b_r31", rdata_b, 32'hFFFFFFFF);
        check("nb_rd_a_r1", nb_rdata_a, 32'h12345678);

        // Register 0 ignores writes and never bypasses.
        we = 1'b1; waddr = 5'd0; wdata = 32'hAAAAAAAA; raddr_a = 5'd0; dbg_addr = 5'd0;
        #1;
        check("r0_during_write", rdata_a, 32'h0);
        tick();
        we = 1'b0;
        check("r0_after_write", rdata_a, 32'h0);
        check("r0_dbg", dbg_data, 32'h0);

        // Bypass versus committed value.
        write_reg(5'd7, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h2;
        raddr_a = 5'd7; raddr_b = 5'd7; dbg_addr = 5'd7;
        #1;
        check("byp_a", rdata_a, 32'h2);
        check("byp_b", rdata_b, 32'h2);
        check("byp_dbg_old", dbg_data, 32'h1);
        check("nobyp_a", nb_rdata_a, 32'h1);
        check("nobyp_b", nb_rdata_b, 32'h1);
        tick();
        we = 1'b0;
        check("byp_dbg_new", dbg_data, 32'h2);
        check("nobyp_a_new", nb_rdata_a, 32'h2);

        // Back-to-back writes to one index: each cycle bypasses its own data, last wins.
        we = 1'b1; waddr = 5'd7; wdata = 32'h3;
        #1;
        check("b2b_byp_1", rdata_a, 32'h3);
        tick();
        wdata = 32'h4;
        #1;
        check("b2b_byp_2", rdata_a, 32'h4);
        check("b2b_dbg_mid", dbg_data, 32'h3);
        tick();
        we = 1'b0;
        check("b2b_last_wins", dbg_data, 32'h4);

        // A write presented with we=0 neither bypasses nor commits.
        waddr = 5'd9; wdata = 32'h5555; raddr_a = 5'd9; dbg_addr = 5'd9;
        #1;
        check("we0_no_bypass", rdata_a, 32'h0);
        tick();
        check("we0_r9_unchanged", dbg_data, 32'h0);
        dbg_addr = 5'd1;
        #1;
        check("r1_retained", dbg_data, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
